// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift-and-correct step per clock, start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err
);
  localparam int DW = 4 * NDIG;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   bcd_sr, bcd_sr_nxt, bcd_step;
  logic [BW-1:0]   bin_sr, bin_sr_nxt, bin_step;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bin_out_nxt;
  logic            busy_nxt, done_nxt, err_nxt;
  logic            in_bad;
  logic [DW+BW-1:0] sh;

  // One reverse double-dabble step: shift right, then take 3 off every digit that now reads >= 8.
  always_comb begin
    sh       = {bcd_sr, bin_sr} >> 1;
    bin_step = sh[BW-1:0];
    bcd_step = '0;
    for (int d = 0; d < NDIG; d++) begin
      bcd_step[4*d +: 4] = sh[BW+4*d +: 4] - (sh[BW+4*d+3] ? 4'd3 : 4'd0);
    end
  end

  always_comb begin
    in_bad = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    bcd_sr_nxt  = bcd_sr;
    bin_sr_nxt  = bin_sr;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    bin_out_nxt = bin_out;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            err_nxt     = 1'b1;
            bin_out_nxt = '0;
            done_nxt    = 1'b1;
          end else begin
            bcd_sr_nxt = bcd_in;
            bin_sr_nxt = '0;
            cnt_nxt    = '0;
            err_nxt    = 1'b0;
            busy_nxt   = 1'b1;
            state_nxt  = CONV;
          end
        end
      end
      CONV: begin
        bcd_sr_nxt = bcd_step;
        bin_sr_nxt = bin_step;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CW'(BW - 1)) begin
          bin_out_nxt = bin_step;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state   <= state_nxt;
      bcd_sr  <= bcd_sr_nxt;
      bin_sr  <= bin_sr_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      bin_out <= bin_out_nxt;
    end
  end

  // A valid input leaves nothing behind in the BCD register after the last step.
  a_bcd_drained : assert property (@(posedge clk) disable iff (!rst_n)
    (state == CONV && cnt == CW'(BW - 1)) |-> (bcd_step == '0));

endmodule
